sa_port_alloc: RTL and testbench

Parametrised switch-allocation output stage for the mesh router. For each of NUM_OUT output ports it arbitrates among NUM_SRC requesting sources (unicast, multicast and further classes) with a round-robin pointer. The grant is locked to one source for the length of a multi-flit packet. The winning flit is registered onto the port under downstream-full backpressure. It sits between the unicast/multicast route stages and the link output registers. It generalises the current fixed two-source, per-flit E/S/L muxing to any port count and source count, and adds wormhole packet locking and a per-source ready return.

---
 rtl/sa_pkg.sv | 22 ++
 rtl/sa_port_alloc_if.sv | 25 ++
 rtl/sa_port_slice.sv | 116 +++++++++++
 rtl/sa_port_alloc.sv | 33 +++
 tb/tb_sa_port_alloc.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/sa_pkg.sv
// Shared types and index helpers for the switch-allocation output stage.
package sa_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } port_state_e;

    // Owner/pointer width; a 1-bit floor keeps the vectors legal for tiny source counts.
    function automatic int unsigned ptr_width(input int unsigned num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    function automatic int unsigned req_lo(input int unsigned port, input int unsigned num_src);
        return port * num_src;
    endfunction

    function automatic int unsigned data_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/sa_port_alloc_if.sv
// Flattened request/output buses of the port allocator.
interface sa_port_alloc_if #(
    parameter int unsigned NUM_OUT  = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DATASIZE = 30
);
    logic [NUM_OUT*NUM_SRC-1:0]          req_valid;
    logic [NUM_OUT*NUM_SRC*DATASIZE-1:0] req_data;
    logic [NUM_OUT*NUM_SRC-1:0]          req_ready;
    logic [NUM_OUT-1:0]                  out_full;
    logic [NUM_OUT-1:0]                  out_valid;
    logic [NUM_OUT*DATASIZE-1:0]         out_data;
    logic [NUM_OUT-1:0]                  out_locked;

    modport master (
        output req_valid, req_data, out_full,
        input  req_ready, out_valid, out_data, out_locked
    );

    modport slave (
        input  req_valid, req_data, out_full,
        output req_ready, out_valid, out_data, out_locked
    );

endinterface

// File: rtl/sa_port_slice.sv
// One output port: round-robin pick with wormhole lock, IDLE/LOCKED FSM and output register.
module sa_port_slice
    import sa_pkg::*;
#(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DATASIZE = 30,
    parameter int unsigned TAIL_BIT = DATASIZE - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC-1:0]           req_valid,
    input  logic [NUM_SRC*DATASIZE-1:0]  req_data,
    output logic [NUM_SRC-1:0]           req_ready,
    input  logic                         out_full,
    output logic                         out_valid,
    output logic [DATASIZE-1:0]          out_data,
    output logic                         out_locked
);

    localparam int unsigned PW = ptr_width(NUM_SRC);
    localparam logic [PW-1:0] LAST = PW'(NUM_SRC - 1);

    port_state_e         state_q, state_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic                out_valid_q, out_valid_d;
    logic [DATASIZE-1:0] out_data_q, out_data_d;

    logic                found;
    logic [PW-1:0]       winner;
    logic [PW-1:0]       cand;
    logic [PW-1:0]       sel;
    logic                take;
    logic [DATASIZE-1:0] flit;

    // First requester at or above ptr, wrapping modulo NUM_SRC.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            cand = PW'((32'(ptr_q) + 32'(i)) % NUM_SRC);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        sel       = (state_q == StLocked) ? owner_q : winner;
        take      = !out_full && ((state_q == StLocked) ? req_valid[owner_q] : found);
        flit      = '0;
        req_ready = '0;
        for (int s = 0; s < int'(NUM_SRC); s++) begin
            if (PW'(s) == sel) begin
                flit = req_data[s*DATASIZE +: DATASIZE];
            end
        end
        if (take) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (!out_full) begin
            out_valid_d = take;
            if (take) begin
                out_data_d = flit;
            end
            unique case (state_q)
                StIdle: begin
                    if (take) begin
                        ptr_d = (winner == LAST) ? '0 : winner + PW'(1);
                        if (!flit[TAIL_BIT]) begin
                            state_d = StLocked;
                            owner_d = winner;
                        end
                    end
                end
                StLocked: begin
                    if (take && flit[TAIL_BIT]) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_locked = (state_q == StLocked);

endmodule

// File: rtl/sa_port_alloc.sv
// Switch-allocation output stage: one independent allocator slice per output port.
module sa_port_alloc
    import sa_pkg::*;
#(
    parameter int unsigned NUM_OUT  = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DATASIZE = 30,
    parameter int unsigned TAIL_BIT = DATASIZE - 1
) (
    input  logic            clk,
    input  logic            rst_n,
    sa_port_alloc_if.slave  bus
);

    for (genvar o = 0; o < int'(NUM_OUT); o++) begin : g_port
        sa_port_slice #(
            .NUM_SRC  (NUM_SRC),
            .DATASIZE (DATASIZE),
            .TAIL_BIT (TAIL_BIT)
        ) u_slice (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_valid  (bus.req_valid[req_lo(o, NUM_SRC) +: NUM_SRC]),
            .req_data   (bus.req_data[data_lo(req_lo(o, NUM_SRC), DATASIZE) +: NUM_SRC*DATASIZE]),
            .req_ready  (bus.req_ready[req_lo(o, NUM_SRC) +: NUM_SRC]),
            .out_full   (bus.out_full[o]),
            .out_valid  (bus.out_valid[o]),
            .out_data   (bus.out_data[data_lo(o, DATASIZE) +: DATASIZE]),
            .out_locked (bus.out_locked[o])
        );
    end

endmodule

// File: tb/tb_sa_port_alloc.sv
// Self-checking bench for sa_port_alloc: vector table on port E plus reset-in-packet sequence.
module tb_sa_port_alloc;

    localparam int unsigned NO = 5;
    localparam int unsigned NS = 2;
    localparam int unsigned DW = 30;
    localparam int unsigned PE = 3;
    localparam int NROWS = 21;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa_port_alloc_if #(.NUM_OUT(NO), .NUM_SRC(NS), .DATASIZE(DW)) bus ();

    sa_port_alloc #(
        .NUM_OUT  (NO),
        .NUM_SRC  (NS),
        .DATASIZE (DW),
        .TAIL_BIT (DW - 1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]    vld;
        logic [1:0]    tl;
        logic          full;
        logic [1:0]    rdy;
        logic          ov;
        logic [DW-1:0] od;
        logic          lk;
    } vec_t;

    typedef struct {
        logic          ov;
        logic [DW-1:0] od;
        logic          lk;
        string         nm;
    } exp_t;

    vec_t tbl[NROWS];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Flit tagged with tail flag, source and row so every acceptance is distinguishable.
    function automatic logic [DW-1:0] fl(input logic t, input int s, input int k);
        return {t, 5'(s), 24'(k)};
    endfunction

    function automatic vec_t mk(input logic [1:0] vld, input logic [1:0] tl, input logic full,
                                input logic [1:0] rdy, input logic ov, input logic [DW-1:0] od,
                                input logic lk);
        vec_t v;
        v.vld = vld; v.tl = tl; v.full = full; v.rdy = rdy; v.ov = ov; v.od = od; v.lk = lk;
        return v;
    endfunction

    task automatic check(input string nm, input logic [NO*DW-1:0] act,
                         input logic [NO*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] vld, input logic [1:0] tl, input logic full,
                         input int k);
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_full  = '0;
        bus.req_valid[PE*NS +: NS] = vld;
        for (int s = 0; s < int'(NS); s++) begin
            bus.req_data[(int'(PE*NS) + s)*int'(DW) +: DW] = fl(tl[s], s, k);
        end
        bus.out_full[PE] = full;
    endtask

    task automatic pop_cmp();
        exp_t e;
        logic [NO-1:0]    ev;
        logic [NO-1:0]    el;
        logic [NO*DW-1:0] ed;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e  = sb.pop_front();
            ev = '0; ev[PE] = e.ov;
            el = '0; el[PE] = e.lk;
            ed = '0; ed[PE*DW +: DW] = e.od;
            check({e.nm, " out_valid"}, bus.out_valid, ev);
            check({e.nm, " out_data"}, bus.out_data, ed);
            check({e.nm, " out_locked"}, bus.out_locked, el);
        end
    endtask

    task automatic step_row(input vec_t v, input int k);
        logic [NO*NS-1:0] er;
        drive(v.vld, v.tl, v.full, k);
        #1;
        er = '0;
        er[PE*NS +: NS] = v.rdy;
        check($sformatf("row%0d req_ready", k), bus.req_ready, er);
        sb.push_back('{v.ov, v.od, v.lk, $sformatf("row%0d", k)});
        @(posedge clk);
        #1;
        pop_cmp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_full  = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset req_ready", bus.req_ready, '0);
        sb.push_back('{1'b0, '0, 1'b0, "reset"});
        pop_cmp();
        sb.push_back('{1'b0, '0, 1'b0, "idle"});
        @(posedge clk);
        #1;
        pop_cmp();

        // Alternating single-flit packets, 3-flit packet, full stall, owner bubbles, lock by s0.
        tbl[0]  = mk(2'b11, 2'b11, 1'b0, 2'b01, 1'b1, fl(1, 0, 0), 1'b0);
        tbl[1]  = mk(2'b11, 2'b11, 1'b0, 2'b10, 1'b1, fl(1, 1, 1), 1'b0);
        tbl[2]  = mk(2'b11, 2'b11, 1'b0, 2'b01, 1'b1, fl(1, 0, 2), 1'b0);
        tbl[3]  = mk(2'b11, 2'b11, 1'b0, 2'b10, 1'b1, fl(1, 1, 3), 1'b0);
        tbl[4]  = mk(2'b01, 2'b11, 1'b0, 2'b01, 1'b1, fl(1, 0, 4), 1'b0);
        tbl[5]  = mk(2'b11, 2'b01, 1'b0, 2'b10, 1'b1, fl(0, 1, 5), 1'b1);
        tbl[6]  = mk(2'b11, 2'b01, 1'b0, 2'b10, 1'b1, fl(0, 1, 6), 1'b1);
        tbl[7]  = mk(2'b11, 2'b11, 1'b0, 2'b10, 1'b1, fl(1, 1, 7), 1'b0);
        tbl[8]  = mk(2'b11, 2'b11, 1'b0, 2'b01, 1'b1, fl(1, 0, 8), 1'b0);
        tbl[9]  = mk(2'b11, 2'b01, 1'b0, 2'b10, 1'b1, fl(0, 1, 9), 1'b1);
        tbl[10] = mk(2'b11, 2'b01, 1'b1, 2'b00, 1'b1, fl(0, 1, 9), 1'b1);
        tbl[11] = mk(2'b11, 2'b01, 1'b1, 2'b00, 1'b1, fl(0, 1, 9), 1'b1);
        tbl[12] = mk(2'b11, 2'b01, 1'b1, 2'b00, 1'b1, fl(0, 1, 9), 1'b1);
        tbl[13] = mk(2'b11, 2'b01, 1'b1, 2'b00, 1'b1, fl(0, 1, 9), 1'b1);
        tbl[14] = mk(2'b11, 2'b01, 1'b0, 2'b10, 1'b1, fl(0, 1, 14), 1'b1);
        tbl[15] = mk(2'b01, 2'b11, 1'b0, 2'b00, 1'b0, fl(0, 1, 14), 1'b1);
        tbl[16] = mk(2'b01, 2'b11, 1'b0, 2'b00, 1'b0, fl(0, 1, 14), 1'b1);
        tbl[17] = mk(2'b11, 2'b11, 1'b0, 2'b10, 1'b1, fl(1, 1, 17), 1'b0);
        tbl[18] = mk(2'b00, 2'b11, 1'b0, 2'b00, 1'b0, fl(1, 1, 17), 1'b0);
        tbl[19] = mk(2'b01, 2'b11, 1'b0, 2'b01, 1'b1, fl(1, 0, 19), 1'b0);
        tbl[20] = mk(2'b01, 2'b10, 1'b0, 2'b01, 1'b1, fl(0, 0, 20), 1'b1);

        for (int k = 0; k < NROWS; k++) begin
            step_row(tbl[k], k);
        end

        // Reset while s0 holds the lock with ptr at 1: lock and pointer must both clear.
        drive(2'b11, 2'b11, 1'b0, 21);
        rst_n = 1'b0;
        sb.push_back('{1'b0, '0, 1'b0, "reset_in_packet"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pop_cmp();
        step_row(mk(2'b11, 2'b11, 1'b0, 2'b01, 1'b1, fl(1, 0, 22), 1'b0), 22);
        step_row(mk(2'b11, 2'b11, 1'b0, 2'b10, 1'b1, fl(1, 1, 23), 1'b0), 23);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
